// File: rtl/vend_pkg.sv
// Shared types and constants for the coin scheduler / dispense sequencer.
package vend_pkg;

  // Coin code carried through the buffer; NONE marks an empty issue slot.
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coin_e;

  // Sequencer states: issue one coin, check the sale result, then dispense.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CHECK = 3'd2,
    VEND  = 3'd3,
    EJECT = 3'd4
  } seq_state_e;

  // Value of one unit of change_i, in cents (one ejected nickel).
  localparam int CHANGE_UNIT_CENTS = 5;

  // Maps an arrival lane (0 nickel, 1 dime, 2 quarter) to its coin code.
  function automatic coin_e coin_from_lane(input int lane);
    case (lane)
      0:       return NICKEL;
      1:       return DIME;
      default: return QUARTER;
    endcase
  endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Bundle of coin, FSM-side and dispense handshake signals of the sequencer.
interface vend_sequencer_if #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          nickel_i;
  logic          dime_i;
  logic          quarter_i;
  logic          vm_nickel_o;
  logic          vm_dime_o;
  logic          vm_quarter_o;
  logic          soda_i;
  logic [2:0]    change_i;
  logic          vend_valid_o;
  logic          vend_ready_i;
  logic          eject_valid_o;
  logic          eject_ready_i;
  logic [2:0]    reject_o;
  logic [CW-1:0] fifo_count_o;
  logic          busy_o;

  // Sequencer side.
  modport master (
    input  nickel_i, dime_i, quarter_i, soda_i, change_i,
           vend_ready_i, eject_ready_i,
    output vm_nickel_o, vm_dime_o, vm_quarter_o, vend_valid_o,
           eject_valid_o, reject_o, fifo_count_o, busy_o
  );

  // Environment side: coin acceptor, vending FSM and dispense mechanics.
  modport slave (
    output nickel_i, dime_i, quarter_i, soda_i, change_i,
           vend_ready_i, eject_ready_i,
    input  vm_nickel_o, vm_dime_o, vm_quarter_o, vend_valid_o,
           eject_valid_o, reject_o, fifo_count_o, busy_o
  );
endinterface

// File: rtl/coin_fifo.sv
// Coin buffer: up to three pushes per cycle (nickel, dime, quarter order),
// one pop per cycle, registered reject flags for coins that do not fit.
module coin_fifo
  import vend_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_nickel,
  input  logic          push_dime,
  input  logic          push_quarter,
  input  logic          pop,
  output coin_e         head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic [2:0]    reject
);

  coin_e         mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [2:0]    reject_reg;
  logic [2:0]    push_req;
  logic [2:0]    accept;
  logic [1:0]    n_acc;
  logic [CW-1:0] free;
  logic [PW-1:0] slot [3];
  logic          do_pop;

  assign push_req = {push_quarter, push_dime, push_nickel};
  assign empty    = (count_reg == '0);
  assign do_pop   = pop && !empty;
  assign head     = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign reject   = reject_reg;

  // Grant lanes in priority order against the space left before this cycle's pop.
  always_comb begin
    free   = CW'(DEPTH) - count_reg;
    accept = '0;
    n_acc  = '0;
    for (int k = 0; k < 3; k++) begin
      if (push_req[k] && (CW'(n_acc) < free)) begin
        accept[k] = 1'b1;
        n_acc     = n_acc + 2'd1;
      end
    end
  end

  // Accepted coins occupy consecutive slots from the write pointer.
  assign slot[0] = wr_ptr_reg;
  assign slot[1] = wr_ptr_reg + PW'(accept[0]);
  assign slot[2] = wr_ptr_reg + PW'(accept[0]) + PW'(accept[1]);

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 3; k++) begin
      if (accept[k]) mem[slot[k]] <= coin_from_lane(k);
    end
  end

  // Pointer, occupancy and reject-flag update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      reject_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(n_acc);
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg  <= count_reg + CW'(n_acc) - CW'(do_pop);
      reject_reg <= push_req & ~accept;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Coin scheduler and dispense sequencer in front of the vending FSM: issues
// buffered coins one per three cycles and runs vend / change ejection.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  vend_sequencer_if.master bus
);

  seq_state_e                  state_reg, state_next;
  logic [2:0]                  ej_cnt_reg, ej_cnt_next;
  logic                        vm_nickel_reg, vm_nickel_next;
  logic                        vm_dime_reg, vm_dime_next;
  logic                        vm_quarter_reg, vm_quarter_next;
  logic                        pop;
  logic                        empty;
  coin_e                       head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [2:0]                  reject;

  coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_nickel  (bus.nickel_i),
    .push_dime    (bus.dime_i),
    .push_quarter (bus.quarter_i),
    .pop          (pop),
    .head         (head),
    .count        (fifo_count),
    .empty        (empty),
    .reject       (reject)
  );

  // Next state, pop request, next coin outputs and change counter.
  always_comb begin
    state_next      = state_reg;
    ej_cnt_next     = ej_cnt_reg;
    pop             = 1'b0;
    vm_nickel_next  = 1'b0;
    vm_dime_next    = 1'b0;
    vm_quarter_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop             = 1'b1;
          vm_nickel_next  = (head == NICKEL);
          vm_dime_next    = (head == DIME);
          vm_quarter_next = (head == QUARTER);
          state_next      = ISSUE;
        end
      end
      ISSUE: state_next = CHECK;
      CHECK: begin
        if (bus.soda_i) begin
          ej_cnt_next = bus.change_i;
          state_next  = VEND;
        end else begin
          state_next = IDLE;
        end
      end
      VEND: begin
        if (bus.vend_ready_i) state_next = (ej_cnt_reg != 3'd0) ? EJECT : IDLE;
      end
      EJECT: begin
        if (bus.eject_ready_i) begin
          ej_cnt_next = ej_cnt_reg - 3'd1;
          if (ej_cnt_reg == 3'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, change counter and registered coin strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      ej_cnt_reg     <= '0;
      vm_nickel_reg  <= 1'b0;
      vm_dime_reg    <= 1'b0;
      vm_quarter_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ej_cnt_reg     <= ej_cnt_next;
      vm_nickel_reg  <= vm_nickel_next;
      vm_dime_reg    <= vm_dime_next;
      vm_quarter_reg <= vm_quarter_next;
    end
  end

  assign bus.vm_nickel_o   = vm_nickel_reg;
  assign bus.vm_dime_o     = vm_dime_reg;
  assign bus.vm_quarter_o  = vm_quarter_reg;
  assign bus.vend_valid_o  = (state_reg == VEND);
  assign bus.eject_valid_o = (state_reg == EJECT);
  assign bus.busy_o        = (state_reg != IDLE);
  assign bus.reject_o      = reject;
  assign bus.fifo_count_o  = fifo_count;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: a transaction-level model predicts
// issued coins, rejects, occupancy and dispense activity; a monitor compares.
module tb_vend_sequencer;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vend_sequencer_if #(.FIFO_DEPTH(DEPTH)) vif ();

  vend_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (vif)
  );

  typedef enum int {M_IDLE, M_ISSUE, M_CHECK, M_VEND, M_EJECT} mphase_t;

  mphase_t m_ph = M_IDLE;
  int      m_ej = 0;
  int      mq[$];
  int      exp_coin_q[$];
  int      exp_rej_q[$];
  int      m_vends = 0, m_ejects = 0, seen_vends = 0, seen_ejects = 0;
  int      total = 0, bad = 0;
  int      soda_knob = 0, change_knob = 0, vrdy_knob = 1, erdy_knob = 1;
  logic    erdy_tog = 1'b0;

  function automatic void chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Reference behaviour, one cycle per call.
  task automatic model_step();
    int       room, issued, rej;
    bit [2:0] arr;
    room   = DEPTH - mq.size();
    issued = 0;
    arr    = {vif.quarter_i, vif.dime_i, vif.nickel_i};
    case (m_ph)
      M_IDLE:  if (mq.size() > 0) begin issued = mq.pop_front(); m_ph = M_ISSUE; end
      M_ISSUE: m_ph = M_CHECK;
      M_CHECK: if (vif.soda_i) begin m_ej = int'(vif.change_i); m_ph = M_VEND; end
               else m_ph = M_IDLE;
      M_VEND:  if (vif.vend_ready_i) begin
                 m_vends++;
                 m_ph = (m_ej != 0) ? M_EJECT : M_IDLE;
               end
      M_EJECT: if (vif.eject_ready_i) begin
                 m_ejects++;
                 m_ej--;
                 if (m_ej == 0) m_ph = M_IDLE;
               end
      default: m_ph = M_IDLE;
    endcase
    rej = 0;
    for (int k = 0; k < 3; k++) begin
      if (arr[k]) begin
        if (room > 0) begin mq.push_back(k + 1); room--; end
        else rej |= (1 << k);
      end
    end
    exp_coin_q.push_back(issued == 0 ? 0 : (1 << (issued - 1)));
    exp_rej_q.push_back(rej);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = M_IDLE;
      m_ej = 0;
      mq.delete();
      exp_coin_q.delete();
      exp_rej_q.delete();
    end else begin
      model_step();
    end
  end

  // Monitor: compares DUT outputs mid-cycle with the model's expectations.
  initial forever begin
    int         ec, er;
    logic [2:0] vm;
    @(negedge clk);
    ec = (exp_coin_q.size() > 0) ? exp_coin_q.pop_front() : 0;
    er = (exp_rej_q.size() > 0) ? exp_rej_q.pop_front() : 0;
    vm = {vif.vm_quarter_o, vif.vm_dime_o, vif.vm_nickel_o};
    chk("vm_coin", int'(vm), ec);
    chk("reject", int'(vif.reject_o), er);
    chk("fifo_count", int'(vif.fifo_count_o), mq.size());
    chk("busy", int'(vif.busy_o), int'(m_ph != M_IDLE));
    chk("vend_valid", int'(vif.vend_valid_o), int'(m_ph == M_VEND));
    chk("eject_valid", int'(vif.eject_valid_o), int'(m_ph == M_EJECT));
    if (vm != 3'b000) $display("coin issued to FSM: {q,d,n}=%b t=%0t", vm, $time);
    if (vif.reject_o != 3'b000) $display("coins rejected: {q,d,n}=%b t=%0t", vif.reject_o, $time);
    if (vif.vend_valid_o && vif.vend_ready_i) begin
      seen_vends++;
      $display("vend accepted t=%0t", $time);
    end
    if (vif.eject_valid_o && vif.eject_ready_i) begin
      seen_ejects++;
      $display("nickel ejected (%0d c) t=%0t", 5, $time);
    end
  end

  task automatic step(input bit n, input bit d, input bit q);
    @(posedge clk);
    #2;
    vif.nickel_i     = n;
    vif.dime_i       = d;
    vif.quarter_i    = q;
    vif.soda_i       = (soda_knob < 0) ? 1'($urandom_range(0, 1)) : 1'(soda_knob);
    vif.change_i     = (change_knob < 0) ? 3'($urandom_range(0, 7)) : 3'(change_knob);
    vif.vend_ready_i = (vrdy_knob < 0) ? 1'($urandom_range(0, 1)) : 1'(vrdy_knob);
    if (erdy_knob == 2) erdy_tog = ~erdy_tog;
    vif.eject_ready_i = (erdy_knob < 0) ? 1'($urandom_range(0, 1)) :
                        (erdy_knob == 2) ? erdy_tog : 1'(erdy_knob);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vif.nickel_i = 0; vif.dime_i = 0; vif.quarter_i = 0;
    vif.soda_i = 0; vif.change_i = 0; vif.vend_ready_i = 0; vif.eject_ready_i = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_count", int'(vif.fifo_count_o), 0);
    chk("reset_busy", int'(vif.busy_o), 0);

    // Single dime, no sale.
    soda_knob = 0; change_knob = 0;
    step(0, 1, 0); idle(6);

    // Three coins in one cycle, issued nickel, dime, quarter.
    step(1, 1, 1); idle(12);

    // Sale with change 3, vend held off, coin arriving mid-dispense.
    soda_knob = 1; change_knob = 3; vrdy_knob = 0; erdy_knob = 2;
    step(0, 0, 1); idle(4);
    soda_knob = 0;
    step(1, 0, 0); idle(3);
    vrdy_knob = 1;
    idle(14);

    // Sale with no change.
    soda_knob = 1; change_knob = 0; erdy_knob = 1;
    step(0, 1, 0); idle(4);
    soda_knob = 0;
    idle(6);

    // Overflow: three coins buffered while vend is stalled, then three more.
    soda_knob = 1; change_knob = 1; vrdy_knob = 0;
    step(0, 1, 0); idle(4);
    soda_knob = 0;
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 1); step(1, 1, 1);
    step(0, 0, 0);
    @(negedge clk);
    chk("overflow_count", int'(vif.fifo_count_o), 4);
    chk("overflow_reject", int'(vif.reject_o), 6);
    vrdy_knob = 1;
    idle(25);

    // Randomised traffic.
    soda_knob = -1; change_knob = -1; vrdy_knob = -1; erdy_knob = -1;
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    soda_knob = 0; vrdy_knob = 1; erdy_knob = 1;
    for (int i = 0; i < 200 && !(m_ph == M_IDLE && mq.size() == 0); i++) step(0, 0, 0);
    @(negedge clk);
    chk("drain_busy", int'(vif.busy_o), 0);
    chk("drain_count", int'(vif.fifo_count_o), 0);

    // Reset in the middle of ejecting change with coins buffered.
    soda_knob = 1; change_knob = 2; vrdy_knob = 0; erdy_knob = 0;
    step(0, 1, 0); idle(4);
    soda_knob = 0;
    step(1, 0, 0); step(0, 0, 1);
    vrdy_knob = 1;
    for (int i = 0; i < 20 && !(m_ph == M_EJECT && m_ej == 2); i++) step(0, 0, 0);
    chk("pre_reset_eject_valid", int'(vif.eject_valid_o), 1);
    chk("pre_reset_count", int'(vif.fifo_count_o), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_eject_valid", int'(vif.eject_valid_o), 0);
    chk("async_rst_vend_valid", int'(vif.vend_valid_o), 0);
    chk("async_rst_busy", int'(vif.busy_o), 0);
    chk("async_rst_count", int'(vif.fifo_count_o), 0);
    chk("async_rst_vm", int'({vif.vm_quarter_o, vif.vm_dime_o, vif.vm_nickel_o}), 0);
    chk("async_rst_reject", int'(vif.reject_o), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(3);
    @(negedge clk);
    chk("post_reset_busy", int'(vif.busy_o), 0);
    chk("post_reset_count", int'(vif.fifo_count_o), 0);

    chk("vend_total", seen_vends, m_vends);
    chk("eject_total", seen_ejects, m_ejects);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
